systolic_feeder_2x2: RTL and testbench

Command-side sequencer for the 2×2 systolic matrix-multiply array. It accepts one pair of 2×2 operand matrices over a valid/ready request channel, then drives the array's start, clear, accumulate and streaming A/B inputs in the required beat order. It waits for the array's done pulse, captures the four results and returns them on a valid/ready response channel. It sits between the vector execution dispatch and the systolic array, and owns the array's control interface exclusively.

---
 rtl/systolic_pkg.sv | 49 ++++
 rtl/systolic_feeder_2x2.sv | 132 +++++++++++++
 tb/tb_systolic_feeder_2x2.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the 2x2 systolic array feeder and array wrapper
package systolic_pkg;

    localparam int unsigned SYS_DATA_WIDTH  = 32;
    localparam int unsigned SYS_ACCUM_WIDTH = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_FEED0,
        S_FEED1,
        S_FLUSH,
        S_WAIT_DONE,
        S_RESP
    } feeder_state_t;

    // Member order puts element 00 in the LSBs of the packed vector.
    typedef struct packed {
        logic [SYS_DATA_WIDTH-1:0] e11;
        logic [SYS_DATA_WIDTH-1:0] e10;
        logic [SYS_DATA_WIDTH-1:0] e01;
        logic [SYS_DATA_WIDTH-1:0] e00;
    } mat2x2_data_t;

    typedef struct packed {
        logic [SYS_ACCUM_WIDTH-1:0] c11;
        logic [SYS_ACCUM_WIDTH-1:0] c10;
        logic [SYS_ACCUM_WIDTH-1:0] c01;
        logic [SYS_ACCUM_WIDTH-1:0] c00;
    } mat2x2_acc_t;

    function automatic mat2x2_data_t unpack_data(input logic [4*SYS_DATA_WIDTH-1:0] v);
        return mat2x2_data_t'(v);
    endfunction

    function automatic logic [4*SYS_DATA_WIDTH-1:0] pack_data(input mat2x2_data_t m);
        return m;
    endfunction

    function automatic mat2x2_acc_t unpack_acc(input logic [4*SYS_ACCUM_WIDTH-1:0] v);
        return mat2x2_acc_t'(v);
    endfunction

    function automatic logic [4*SYS_ACCUM_WIDTH-1:0] pack_acc(input mat2x2_acc_t m);
        return m;
    endfunction

endpackage

// File: rtl/systolic_feeder_2x2.sv
// rtl/systolic_feeder_2x2.sv - sequences one 2x2 operand pair into the systolic array and returns its results
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ACCUM_WIDTH    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [4*DATA_WIDTH-1:0]  req_a_i,
    input  logic [4*DATA_WIDTH-1:0]  req_b_i,
    input  logic                     req_accumulate_i,
    output logic                     arr_start_o,
    output logic                     arr_clear_o,
    output logic                     arr_accumulate_o,
    output logic [DATA_WIDTH-1:0]    arr_a_row0_o,
    output logic [DATA_WIDTH-1:0]    arr_a_row1_o,
    output logic                     arr_a_valid_o,
    output logic [DATA_WIDTH-1:0]    arr_b_col0_o,
    output logic [DATA_WIDTH-1:0]    arr_b_col1_o,
    output logic                     arr_b_valid_o,
    input  logic                     arr_busy_i,
    input  logic                     arr_done_i,
    input  logic [ACCUM_WIDTH-1:0]   arr_c00_i,
    input  logic [ACCUM_WIDTH-1:0]   arr_c01_i,
    input  logic [ACCUM_WIDTH-1:0]   arr_c10_i,
    input  logic [ACCUM_WIDTH-1:0]   arr_c11_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [4*ACCUM_WIDTH-1:0] rsp_c_o,
    output logic                     rsp_err_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    feeder_state_t             state_q, state_d;
    logic [4*DATA_WIDTH-1:0]   a_q, b_q;
    logic                      acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [4*ACCUM_WIDTH-1:0]  rsp_c_q;
    logic                      rsp_err_q;
    logic                      counting, expired, done_hit;
    logic                      unused_busy;

    assign unused_busy = arr_busy_i;

    assign counting = state_q inside {S_FEED0, S_FEED1, S_FLUSH, S_WAIT_DONE};
    assign expired  = counting && (cnt_q == CNT_LAST);
    // done is only honoured while waiting for it; it beats a coincident expiry
    assign done_hit = (state_q == S_WAIT_DONE) && arr_done_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid_i) state_d = req_accumulate_i ? S_START : S_CLEAR;
            S_CLEAR:     state_d = S_START;
            S_START:     state_d = S_FEED0;
            S_FEED0:     state_d = expired ? S_RESP : S_FEED1;
            S_FEED1:     state_d = expired ? S_RESP : S_FLUSH;
            S_FLUSH:     state_d = expired ? S_RESP : S_WAIT_DONE;
            S_WAIT_DONE: if (done_hit || expired) state_d = S_RESP;
            S_RESP:      if (rsp_ready_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid_i) begin
                a_q   <= req_a_i;
                b_q   <= req_b_i;
                acc_q <= req_accumulate_i;
            end
            if (state_q == S_START) begin
                cnt_q <= '0;
            end else if (counting) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (done_hit) begin
                rsp_c_q   <= {arr_c11_i, arr_c10_i, arr_c01_i, arr_c00_i};
                rsp_err_q <= 1'b0;
            end else if (expired) begin
                rsp_c_q   <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign req_ready_o      = (state_q == S_IDLE);
    assign arr_clear_o      = (state_q == S_CLEAR);
    assign arr_start_o      = (state_q == S_START);
    assign arr_accumulate_o = acc_q;
    assign arr_a_valid_o    = state_q inside {S_FEED0, S_FEED1};
    assign arr_b_valid_o    = state_q inside {S_FEED0, S_FEED1};
    assign rsp_valid_o      = (state_q == S_RESP);
    assign rsp_c_o          = rsp_c_q;
    assign rsp_err_o        = rsp_err_q;

    // Beat k carries column k of A and row k of B; the array does the skewing.
    always_comb begin
        arr_a_row0_o = '0;
        arr_a_row1_o = '0;
        arr_b_col0_o = '0;
        arr_b_col1_o = '0;
        if (state_q == S_FEED0) begin
            arr_a_row0_o = a_q[0*DATA_WIDTH +: DATA_WIDTH];
            arr_a_row1_o = a_q[2*DATA_WIDTH +: DATA_WIDTH];
            arr_b_col0_o = b_q[0*DATA_WIDTH +: DATA_WIDTH];
            arr_b_col1_o = b_q[1*DATA_WIDTH +: DATA_WIDTH];
        end else if (state_q == S_FEED1) begin
            arr_a_row0_o = a_q[1*DATA_WIDTH +: DATA_WIDTH];
            arr_a_row1_o = a_q[3*DATA_WIDTH +: DATA_WIDTH];
            arr_b_col0_o = b_q[2*DATA_WIDTH +: DATA_WIDTH];
            arr_b_col1_o = b_q[3*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// tb/tb_systolic_feeder_2x2.sv - self-checking bench for systolic_feeder_2x2 with a behavioural array stub
module tb_systolic_feeder_2x2;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i, req_ready_o, req_accumulate_i;
    logic [4*DW-1:0] req_a_i, req_b_i;
    logic            arr_start_o, arr_clear_o, arr_accumulate_o;
    logic [DW-1:0]   arr_a_row0_o, arr_a_row1_o, arr_b_col0_o, arr_b_col1_o;
    logic            arr_a_valid_o, arr_b_valid_o;
    logic            arr_busy_i, arr_done_i;
    logic [AW-1:0]   arr_c00_i, arr_c01_i, arr_c10_i, arr_c11_i;
    logic            rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [4*AW-1:0] rsp_c_o;

    always #5 clk_i = ~clk_i;

    systolic_feeder_2x2 #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_accumulate_i(req_accumulate_i),
        .arr_start_o(arr_start_o), .arr_clear_o(arr_clear_o), .arr_accumulate_o(arr_accumulate_o),
        .arr_a_row0_o(arr_a_row0_o), .arr_a_row1_o(arr_a_row1_o), .arr_a_valid_o(arr_a_valid_o),
        .arr_b_col0_o(arr_b_col0_o), .arr_b_col1_o(arr_b_col1_o), .arr_b_valid_o(arr_b_valid_o),
        .arr_busy_i(arr_busy_i), .arr_done_i(arr_done_i),
        .arr_c00_i(arr_c00_i), .arr_c01_i(arr_c01_i), .arr_c10_i(arr_c10_i), .arr_c11_i(arr_c11_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_c_o(rsp_c_o), .rsp_err_o(rsp_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // array stub configuration (written by the test sequence)
    int          cfg_delay = 2;
    bit          cfg_never = 1'b0;
    bit          cfg_spur  = 1'b0;
    bit          cfg_ovr   = 1'b0;
    logic [AW-1:0] cfg_c00 = '0;

    // array stub observations (written only by the stub)
    logic [AW-1:0] st_c[4];
    int start_cnt = 0, clear_cnt = 0, start_cyc = 0, beat0_cyc = 0, done_cyc = 0, zero_viol = 0;
    logic acc_at_start = 1'b0;

    // Behavioural array: accumulates the outer product of each beat, raises done cfg_delay cycles after the last beat.
    initial begin
        int beats, wcnt;
        bit armed;
        beats = 0; wcnt = 0; armed = 1'b0;
        arr_done_i = 1'b0; arr_busy_i = 1'b0;
        arr_c00_i = '0; arr_c01_i = '0; arr_c10_i = '0; arr_c11_i = '0;
        for (int i = 0; i < 4; i++) st_c[i] = '0;
        forever begin
            @(negedge clk_i);
            arr_done_i = 1'b0;
            if (!rst_ni) begin
                for (int i = 0; i < 4; i++) st_c[i] = '0;
                armed = 1'b0;
                arr_busy_i = 1'b0;
                continue;
            end
            if (arr_clear_o) begin
                for (int i = 0; i < 4; i++) st_c[i] = '0;
                clear_cnt++;
            end
            if (arr_start_o) begin
                start_cnt++;
                start_cyc = cyc;
                acc_at_start = arr_accumulate_o;
                armed = 1'b1; beats = 0; wcnt = 0;
            end
            if (arr_a_valid_o && arr_b_valid_o) begin
                if (beats == 0) beat0_cyc = cyc;
                st_c[0] += 64'(arr_a_row0_o) * 64'(arr_b_col0_o);
                st_c[1] += 64'(arr_a_row0_o) * 64'(arr_b_col1_o);
                st_c[2] += 64'(arr_a_row1_o) * 64'(arr_b_col0_o);
                st_c[3] += 64'(arr_a_row1_o) * 64'(arr_b_col1_o);
                beats++;
                if (beats == 2 && cfg_spur) begin
                    arr_done_i = 1'b1;
                    arr_c00_i  = 64'h55;
                end
            end else if (arr_a_valid_o || arr_b_valid_o) begin
                zero_viol++;
            end else if ((arr_a_row0_o | arr_a_row1_o | arr_b_col0_o | arr_b_col1_o) != '0) begin
                zero_viol++;
            end
            if (armed && beats == 2) begin
                if (wcnt == cfg_delay && !cfg_never) begin
                    arr_done_i = 1'b1;
                    arr_c00_i  = cfg_ovr ? cfg_c00 : st_c[0];
                    arr_c01_i  = st_c[1];
                    arr_c10_i  = st_c[2];
                    arr_c11_i  = st_c[3];
                    done_cyc   = cyc;
                    armed      = 1'b0;
                end
                wcnt++;
            end
            arr_busy_i = armed;
        end
    end

    typedef struct {
        logic [4*DW-1:0] a;
        logic [4*DW-1:0] b;
        bit              acc;
        int              delay;
        bit              never;
        bit              spur;
        bit              ovr;
        bit              keep;
        int              stall;
        bit              use_model;
        logic [4*AW-1:0] exp_c;
        bit              exp_err;
    } vec_t;

    logic [AW-1:0] ref_c[4];

    function automatic logic [4*DW-1:0] mat(input int x00, input int x01, input int x10, input int x11);
        return {DW'(x11), DW'(x10), DW'(x01), DW'(x00)};
    endfunction

    function automatic logic [4*AW-1:0] cmat(input longint c00, input longint c01, input longint c10, input longint c11);
        return {AW'(c11), AW'(c10), AW'(c01), AW'(c00)};
    endfunction

    function automatic vec_t mkvec(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input bit acc,
                                   input int delay, input bit never, input bit spur, input bit keep,
                                   input int stall, input logic [4*AW-1:0] exp_c, input bit exp_err);
        vec_t v;
        v.a = a; v.b = b; v.acc = acc; v.delay = delay; v.never = never; v.spur = spur;
        v.ovr = spur; v.keep = keep; v.stall = stall; v.use_model = 1'b0;
        v.exp_c = exp_c; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [4*DW-1:0] a, b;
        logic [4*AW-1:0] exp_c, held;
        bit              exp_err, ready_bad, stable_bad;
        int              pa, s0, c0, n, rsp_cyc;
        a = v.a; b = v.b;
        if (!v.acc) for (int i = 0; i < 4; i++) ref_c[i] = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++)
                    ref_c[i*2+j] += 64'(a[(i*2+k)*DW +: DW]) * 64'(b[(k*2+j)*DW +: DW]);
        if (v.use_model) begin
            exp_c   = v.never ? '0 : {ref_c[3], ref_c[2], ref_c[1], ref_c[0]};
            exp_err = v.never;
        end else begin
            exp_c   = v.exp_c;
            exp_err = v.exp_err;
        end
        cfg_delay = v.delay; cfg_never = v.never; cfg_spur = v.spur; cfg_ovr = v.ovr; cfg_c00 = 64'hAA;
        s0 = start_cnt; c0 = clear_cnt;
        check({tag, " ready_in_idle"}, req_ready_o, 1);
        req_valid_i = 1'b1; req_a_i = v.a; req_b_i = v.b; req_accumulate_i = v.acc;
        pa = cyc;
        @(posedge clk_i); #1;
        if (!v.keep) req_valid_i = 1'b0;
        n = 0; ready_bad = 1'b0;
        while (!rsp_valid_o && n < 60) begin
            @(negedge clk_i);
            if (req_ready_o) ready_bad = 1'b1;
            n++;
        end
        rsp_cyc = cyc;
        check({tag, " rsp_valid"}, rsp_valid_o, 1);
        check({tag, " rsp_c"}, rsp_c_o, exp_c);
        check({tag, " rsp_err"}, rsp_err_o, exp_err);
        check({tag, " start_pulses"}, start_cnt - s0, 1);
        check({tag, " clear_pulses"}, clear_cnt - c0, v.acc ? 0 : 1);
        check({tag, " start_latency"}, start_cyc - pa, v.acc ? 1 : 2);
        check({tag, " beat_latency"}, beat0_cyc - start_cyc, 1);
        check({tag, " accumulate_out"}, acc_at_start, v.acc);
        if (v.never) check({tag, " timeout_latency"}, rsp_cyc - beat0_cyc, TO);
        else         check({tag, " done_to_rsp"}, rsp_cyc - done_cyc, 1);
        held = rsp_c_o; stable_bad = 1'b0;
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk_i);
            if (rsp_c_o !== held || !rsp_valid_o || req_ready_o) stable_bad = 1'b1;
        end
        if (v.stall > 0) check({tag, " rsp_stall_stable"}, stable_bad, 0);
        check({tag, " ready_low_busy"}, ready_bad, 0);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check({tag, " idle_after_hs"}, {req_ready_o, rsp_valid_o}, 2'b10);
        @(negedge clk_i);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   n;
        logic [4*DW-1:0] ma, mb;
        req_valid_i = 1'b0; req_accumulate_i = 1'b0; req_a_i = '0; req_b_i = '0; rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) ref_c[i] = '0;

        ma = mat(1, 2, 3, 4);
        mb = mat(5, 6, 7, 8);
        tbl[0] = mkvec(ma, mb, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0, cmat(19, 22, 43, 50), 1'b0);
        tbl[1] = mkvec(ma, mb, 1'b1, 5, 1'b0, 1'b0, 1'b0, 0, cmat(38, 44, 86, 100), 1'b0);
        tbl[2] = mkvec(ma, mb, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        tbl[3] = mkvec(ma, mb, 1'b1, 2, 1'b0, 1'b0, 1'b1, 5, cmat(38, 44, 86, 100), 1'b0);
        tbl[4] = mkvec(mat(2, 0, 0, 0), mat(3, 0, 0, 0), 1'b0, 4, 1'b0, 1'b1, 1'b0, 1, cmat(32'hAA, 0, 0, 0), 1'b0);
        tbl[5] = mkvec(mat(1, 0, 0, 1), mat(1, 1, 1, 1), 1'b1, 14, 1'b0, 1'b0, 1'b0, 0, cmat(7, 1, 1, 1), 1'b0);

        repeat (3) @(negedge clk_i);
        check("reset ready", req_ready_o, 1);
        check("reset outs", {arr_start_o, arr_clear_o, arr_accumulate_o, arr_a_row0_o, arr_a_row1_o,
                             arr_a_valid_o, arr_b_col0_o, arr_b_col1_o, arr_b_valid_o,
                             rsp_valid_o, rsp_err_o, rsp_c_o}, '0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int t = 0; t < 6; t++) run_txn(tbl[t], $sformatf("vec%0d", t));

        for (int t = 0; t < 10; t++) begin
            v.a = {$urandom, $urandom, $urandom, $urandom};
            v.b = {$urandom, $urandom, $urandom, $urandom};
            v.acc = 1'($urandom_range(0, 1));
            v.delay = $urandom_range(2, 13);
            v.never = 1'b0; v.spur = 1'b0; v.ovr = 1'b0; v.keep = 1'b0;
            v.stall = $urandom_range(0, 3);
            v.use_model = 1'b1; v.exp_c = '0; v.exp_err = 1'b0;
            run_txn(v, $sformatf("rnd%0d", t));
        end

        // asynchronous reset in the middle of the first beat
        req_valid_i = 1'b1; req_a_i = ma; req_b_i = mb; req_accumulate_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!arr_a_valid_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        check("midrst reached feed0", arr_a_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst ready", req_ready_o, 1);
        check("midrst outs", {arr_start_o, arr_clear_o, arr_accumulate_o, arr_a_row0_o, arr_a_row1_o,
                              arr_a_valid_o, arr_b_col0_o, arr_b_col1_o, arr_b_valid_o,
                              rsp_valid_o, rsp_err_o, rsp_c_o}, '0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) ref_c[i] = '0;
        @(negedge clk_i);
        v.a = mat(1, 2, 3, 4); v.b = mat(5, 6, 7, 8); v.acc = 1'b1; v.delay = 3;
        v.never = 1'b0; v.spur = 1'b0; v.ovr = 1'b0; v.keep = 1'b0; v.stall = 0;
        v.use_model = 1'b0; v.exp_c = cmat(19, 22, 43, 50); v.exp_err = 1'b0;
        run_txn(v, "postrst");

        check("stream idle zero", zero_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
